// File: rtl/decode_queue_controller.sv
// rtl/decode_queue_controller.sv - instruction byte queue and issue sequencer ahead of decode; optional DECODE_QUEUE_STATS_EN
module decode_queue_controller #(
    parameter int DEPTH       = 32,
    parameter int FETCH_BYTES = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_fetch_valid,
    input  logic [8*FETCH_BYTES-1:0] i_fetch_data,
    output logic                     o_fetch_ready,
    output logic                     o_fetch_redirect,
    output logic [31:0]              o_fetch_addr,
    output logic [7:0]               o_window [0:15],
    output logic [4:0]               o_window_bytes,
    input  logic [3:0]               i_decode_length,
    input  logic                     i_decode_error,
    output logic                     o_issue_valid,
    input  logic                     i_issue_ready,
    output logic [3:0]               o_issue_length,
    output logic [31:0]              o_issue_eip,
    input  logic                     i_flush,
    input  logic [31:0]              i_flush_eip,
`ifdef DECODE_QUEUE_STATS_EN
    output logic [31:0]              o_issue_count,
    output logic [31:0]              o_stall_count,
`endif
    output logic                     o_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      buf_q [DEPTH];
    logic [7:0]      buf_d [DEPTH];
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     eip_q, eip_d;
    logic            fetch_fire;
    logic            issue_fire;
`ifdef DECODE_QUEUE_STATS_EN
    logic [31:0]     issue_count_q, issue_count_d;
    logic [31:0]     stall_count_q, stall_count_d;
`endif

    // Handshake qualifiers and decoder-facing window; flush masks both handshakes in its own cycle
    always_comb begin
        o_fetch_ready  = (state_q == S_RUN) && !i_flush && (count_q <= CW'(DEPTH - FETCH_BYTES));
        o_issue_valid  = (state_q == S_RUN) && !i_flush && !i_decode_error &&
                         (i_decode_length != 4'd0) && (CW'(i_decode_length) <= count_q);
        o_issue_length = i_decode_length;
        o_issue_eip    = eip_q;
        o_fault        = (state_q == S_FAULT);
        o_fetch_redirect = (state_q == S_FLUSH);
        o_fetch_addr   = (state_q == S_FLUSH) ? eip_q : 32'h0;
        fetch_fire     = i_fetch_valid && o_fetch_ready;
        issue_fire     = o_issue_valid && i_issue_ready;
        o_window_bytes = (count_q >= CW'(16)) ? 5'd16 : 5'(count_q);
        for (int k = 0; k < 16; k++) begin
            o_window[k] = (CW'(k) < count_q) ? buf_q[rd_q + PW'(k)] : 8'h00;
        end
    end

    // Next-state: flush overrides everything, otherwise fetch append and issue retire in parallel
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        eip_d   = eip_q;
        for (int i = 0; i < DEPTH; i++) begin
            buf_d[i] = buf_q[i];
        end
`ifdef DECODE_QUEUE_STATS_EN
        issue_count_d = issue_count_q + (issue_fire ? 32'd1 : 32'd0);
        stall_count_d = stall_count_q + ((o_issue_valid && !i_issue_ready) ? 32'd1 : 32'd0);
`endif
        if (i_flush) begin
            state_d = S_FLUSH;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            eip_d   = i_flush_eip;
        end else begin
            case (state_q)
                S_FLUSH: state_d = S_RUN;
                S_RUN:   if (i_decode_error && (count_q >= CW'(15))) state_d = S_FAULT;
                default: state_d = state_q;
            endcase
            if (fetch_fire) begin
                for (int i = 0; i < FETCH_BYTES; i++) begin
                    buf_d[wr_q + PW'(i)] = i_fetch_data[8*i +: 8];
                end
                wr_d = wr_q + PW'(FETCH_BYTES);
            end
            if (issue_fire) begin
                rd_d  = rd_q + PW'(i_decode_length);
                eip_d = eip_q + 32'(i_decode_length);
            end
            count_d = count_q + (fetch_fire ? CW'(FETCH_BYTES) : CW'(0))
                              - (issue_fire ? CW'(i_decode_length) : CW'(0));
        end
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_RUN;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            eip_q   <= '0;
`ifdef DECODE_QUEUE_STATS_EN
            issue_count_q <= '0;
            stall_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            eip_q   <= eip_d;
`ifdef DECODE_QUEUE_STATS_EN
            issue_count_q <= issue_count_d;
            stall_count_q <= stall_count_d;
`endif
        end
    end

    // Byte storage; contents beyond count are never visible, so no reset is needed
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= buf_d[i];
        end
    end

`ifdef DECODE_QUEUE_STATS_EN
    assign o_issue_count = issue_count_q;
    assign o_stall_count = stall_count_q;
`endif

endmodule
